// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
// Shared definitions for the UART TX scheduler: the register map of the
// UART transmit slave, the bit positions inside its STATUS register, and
// the scheduler FSM state encoding.
package uart_tx_sched_pkg;

    // UART TX slave register map
    localparam logic [3:0] UART_ADR_STATUS = 4'h0;
    localparam logic [3:0] UART_ADR_DATA   = 4'h1;

    // STATUS register: read bit = transmitter ready, write bit = start
    localparam int TX_READY_BIT = 0;
    localparam int TX_START_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_ST  = 3'd1,
        ST_RD_W   = 3'd2,
        ST_WR_D   = 3'd3,
        ST_WR_D_W = 3'd4,
        ST_WR_E   = 3'd5,
        ST_WR_E_W = 3'd6,
        ST_GUARD  = 3'd7
    } state_e;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// uart_tx_sched_rr_arbiter
// Combinational round-robin picker: returns the first asserted request at
// or after the pointer, wrapping modulo NREQ.
// Ports:
//   req_i      request vector
//   ptr_i      highest-priority index this round
//   gnt_oh_o   one-hot grant (all zero when no request)
//   gnt_idx_o  index of the granted request
//   any_o      at least one request is asserted
module uart_tx_sched_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_oh_o,
    output logic [$clog2(NREQ)-1:0] gnt_idx_o,
    output logic                    any_o
);

    localparam int GW = $clog2(NREQ);

    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return GW'(sum);
    endfunction

    // Scan from the farthest offset back to the pointer so the closest
    // asserted request is the one left standing.
    always_comb begin
        gnt_idx_o = '0;
        any_o     = 1'b0;
        gnt_oh_o  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[wrap_add(ptr_i, k)]) begin
                gnt_idx_o = wrap_add(ptr_i, k);
                any_o     = 1'b1;
            end
        end
        if (any_o) begin
            gnt_oh_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Wishbone master that owns the UART TX slave and feeds it bytes from NREQ
// requesters in round-robin order. Per byte: poll STATUS until ready, write
// DATAREG, write STATUS start bit, then hold off for GUARD_CYC cycles.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   req_valid_i/data_i   per-requester byte offer (byte i in [8i+7:8i])
//   req_ready_o          one-cycle one-hot pulse when a byte is taken
//   wb_*                 single-strobe Wishbone master towards the UART
//   busy_o               FSM not in IDLE
//   grant_o              requester currently served
//   err_o / err_clr_i    sticky ack-timeout flag and its clear
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for any request; arbitrates and captures byte
// RD_ST     | STATUS read strobe on the bus
// RD_W      | waiting for STATUS read ack; re-poll if not ready
// WR_D      | DATAREG write strobe with captured byte
// WR_D_W    | waiting for DATAREG write ack
// WR_E      | STATUS write strobe (start)
// WR_E_W    | waiting for start write ack
// GUARD     | idle gap before the UART is polled again
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int         NREQ        = 4,
    parameter logic [3:0] ADR_STATUS  = UART_ADR_STATUS,
    parameter logic [3:0] ADR_DATA    = UART_ADR_DATA,
    parameter int         ACK_TIMEOUT = 16,
    parameter int         GUARD_CYC   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [8*NREQ-1:0]       req_data_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic [3:0]              wb_adr_o,
    output logic [7:0]              wb_dat_o,
    input  logic [7:0]              wb_dat_i,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    input  logic                    wb_ack_i,
    output logic                    busy_o,
    output logic [$clog2(NREQ)-1:0] grant_o,
    output logic                    err_o,
    input  logic                    err_clr_i
);

    localparam int         GW        = $clog2(NREQ);
    localparam int         TW        = $clog2(ACK_TIMEOUT);
    localparam int         CW        = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [7:0] START_CMD = 8'(1 << TX_START_BIT);

    state_e          state;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   ptr_next;
    logic [7:0]      tx_byte;
    logic [TW-1:0]   ack_tmr;
    logic [CW-1:0]   guard_tmr;
    logic            in_wait;
    logic            ack_to;

    logic [NREQ-1:0] arb_oh;
    logic [GW-1:0]   arb_idx;
    logic            arb_any;

    logic            unused_dat;

    assign unused_dat = ^wb_dat_i;

    uart_tx_sched_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req_i    (req_valid_i),
        .ptr_i    (rr_ptr),
        .gnt_oh_o (arb_oh),
        .gnt_idx_o(arb_idx),
        .any_o    (arb_any)
    );

    assign in_wait  = (state == ST_RD_W) || (state == ST_WR_D_W) || (state == ST_WR_E_W);
    // The timer reaches zero on the last cycle an ack is still accepted,
    // so err_o becomes visible exactly ACK_TIMEOUT cycles after the strobe.
    assign ack_to   = in_wait && !wb_ack_i && (ack_tmr == '0);
    assign ptr_next = (grant_o == GW'(NREQ - 1)) ? '0 : grant_o + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            tx_byte     <= '0;
            ack_tmr     <= '0;
            guard_tmr   <= '0;
            req_ready_o <= '0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            busy_o      <= 1'b0;
            grant_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            req_ready_o <= '0;
            wb_stb_o    <= 1'b0;

            if (err_clr_i) begin
                err_o <= 1'b0;
            end else if (ack_to) begin
                err_o <= 1'b1;
            end

            if (ack_to) begin
                // Abandon the byte but still move the pointer past the requester.
                state  <= ST_IDLE;
                busy_o <= 1'b0;
                rr_ptr <= ptr_next;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arb_any) begin
                            tx_byte     <= req_data_i[{arb_idx, 3'b000} +: 8];
                            req_ready_o <= arb_oh;
                            grant_o     <= arb_idx;
                            busy_o      <= 1'b1;
                            wb_stb_o    <= 1'b1;
                            wb_adr_o    <= ADR_STATUS;
                            wb_we_o     <= 1'b0;
                            wb_dat_o    <= '0;
                            state       <= ST_RD_ST;
                        end
                    end
                    ST_RD_ST: begin
                        ack_tmr <= TW'(ACK_TIMEOUT - 2);
                        state   <= ST_RD_W;
                    end
                    ST_RD_W: begin
                        if (wb_ack_i) begin
                            wb_stb_o <= 1'b1;
                            if (wb_dat_i[TX_READY_BIT]) begin
                                wb_adr_o <= ADR_DATA;
                                wb_we_o  <= 1'b1;
                                wb_dat_o <= tx_byte;
                                state    <= ST_WR_D;
                            end else begin
                                state    <= ST_RD_ST;
                            end
                        end else begin
                            ack_tmr <= ack_tmr - 1'b1;
                        end
                    end
                    ST_WR_D: begin
                        ack_tmr <= TW'(ACK_TIMEOUT - 2);
                        state   <= ST_WR_D_W;
                    end
                    ST_WR_D_W: begin
                        if (wb_ack_i) begin
                            wb_stb_o <= 1'b1;
                            wb_adr_o <= ADR_STATUS;
                            wb_we_o  <= 1'b1;
                            wb_dat_o <= START_CMD;
                            state    <= ST_WR_E;
                        end else begin
                            ack_tmr <= ack_tmr - 1'b1;
                        end
                    end
                    ST_WR_E: begin
                        ack_tmr <= TW'(ACK_TIMEOUT - 2);
                        state   <= ST_WR_E_W;
                    end
                    ST_WR_E_W: begin
                        if (wb_ack_i) begin
                            if (GUARD_CYC == 0) begin
                                state  <= ST_IDLE;
                                busy_o <= 1'b0;
                                rr_ptr <= ptr_next;
                            end else begin
                                guard_tmr <= CW'(GUARD_CYC - 1);
                                state     <= ST_GUARD;
                            end
                        end else begin
                            ack_tmr <= ack_tmr - 1'b1;
                        end
                    end
                    ST_GUARD: begin
                        if (guard_tmr == '0) begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                            rr_ptr <= ptr_next;
                        end else begin
                            guard_tmr <= guard_tmr - 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Wishbone master that shares the single UART transmit port slave among NREQ byte requesters, using round-robin arbitration.
- For each granted byte it runs the fixed register sequence: poll STATUS until ready, write DATAREG, write STATUS bit0=1 (start).
- Sits between on-chip byte producers (debug, telemetry) and the UART TX slave. It owns the slave's bus exclusively.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADR_STATUS, 4'h0, STATUS register address; value comes from the shared reg-defs package.
- ADR_DATA, 4'h1, DATAREG address; value comes from the shared reg-defs package.
- ACK_TIMEOUT, 16, cycles to wait for wb_ack_i before aborting a transaction.
- GUARD_CYC, 2, idle cycles after the start write before polling STATUS again.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NREQ  requester i has a byte pending.
- req_data_i  in  8*NREQ  byte for requester i, in slice [8i+7:8i].
- req_ready_o  out  NREQ  one-hot, one-cycle pulse when requester i's byte is captured.
- wb_adr_o  out  4  slave address.
- wb_dat_o  out  8  write data.
- wb_dat_i  in  8  read data; bit0 = tx ready.
- wb_stb_o  out  1  strobe, one-cycle pulse per transaction.
- wb_we_o  out  1  1 = write.
- wb_ack_i  in  1  slave acknowledge.
- busy_o  out  1  1 whenever the FSM is not in IDLE.
- grant_o  out  $clog2(NREQ)  index of the requester currently being served.
- err_o  out  1  sticky flag, set on ack timeout.
- err_clr_i  in  1  clears err_o.

Behaviour:
- Reset (async, rst_ni=0) forces:
  - FSM to IDLE.
  - All outputs to 0, including grant_o=0 and err_o=0.
  - Round-robin pointer to 0.
  - Captured byte register to 0.
- A reset mid-transaction abandons the transaction immediately. No bus cleanup is attempted.
- Bus rule:
  - wb_stb_o is high for exactly one cycle per transaction. wb_adr_o, wb_we_o and wb_dat_o are valid in that cycle and held until ack or abort.
  - The FSM then waits with stb low. wb_ack_i is examined only in wait states.
  - If no ack arrives within ACK_TIMEOUT cycles of the strobe, err_o is set and the FSM returns to IDLE. The captured byte is dropped.
  - On timeout the round-robin pointer still advances past the granted requester.
- States:
  - IDLE: if any req_valid_i is set, pick the first set index at or after the RR pointer, wrapping modulo NREQ. Capture its byte, pulse its req_ready_o, set grant_o, go to RD_ST.
  - RD_ST: issue a STATUS read strobe, go to RD_W.
  - RD_W: on ack with wb_dat_i[0]=1 go to WR_D. On ack with wb_dat_i[0]=0 go back to RD_ST (re-poll).
  - WR_D: issue a DATAREG write strobe with the captured byte, go to WR_D_W.
  - WR_D_W: on ack go to WR_E.
  - WR_E: issue a STATUS write strobe with dat=8'h01, go to WR_E_W.
  - WR_E_W: on ack go to GUARD.
  - GUARD: count GUARD_CYC cycles. Then set the RR pointer to (grant+1) mod NREQ and go to IDLE.
- Latency: an idle bus with an immediately ready UART gives request-to-IDLE of 1 + 3×2 + GUARD_CYC cycles, assuming the ack arrives the cycle after the strobe.
- Arbitration boundaries:
  - Requests that rise or fall during a transaction are ignored until IDLE.
  - If only the pointer's own requester is valid, it is granted even though it was served last.
  - Pointer wrap: after serving NREQ-1 the pointer returns to 0.
- err_o behaviour:
  - err_clr_i has priority over a simultaneous timeout set, so err_o clears.
  - err_o does not block further operation.
- An ack arriving outside a wait state is ignored.

Decomposition:
- Shared package holds:
  - STATUS/DATAREG address constants, reusing the existing reg-defs include.
  - The FSM state encoding.
  - The STATUS bit index for tx ready and start.
- One natural sub-module, rr_arbiter:
  - Inputs: NREQ request vector and pointer.
  - Outputs: one-hot grant and grant index. Purely combinational.
  - Reusable by other shared ports.

Test Plan:
- Single byte: req_valid_i=4'b0001, data 8'hA5, UART ready on first poll.
  - req_ready_o[0] pulses once.
  - Bus sequence is: read 0x0; write 0x1 = A5; write 0x0 = 01.
  - busy_o returns to 0 after 7+GUARD_CYC cycles.
- Re-poll: slave returns bit0=0 for 3 reads and then 1.
  - Exactly 4 STATUS reads occur before the DATAREG write, and the byte is written unchanged.
- Round-robin: all 4 requesters held valid with bytes 10,11,12,13.
  - Grant order is 0,1,2,3,0.
  - DATAREG writes are 10,11,12,13,10.
- Timeout: slave never acks the first read.
  - err_o rises ACK_TIMEOUT cycles after the strobe and the FSM returns to IDLE.
  - The next request is served normally.
  - err_clr_i clears err_o; a simultaneous timeout plus clear leaves err_o=0.
- Async reset asserted in WR_E_W.
  - All outputs go to 0 without waiting for a clock edge.
  - After release the pointer is 0 and requester 0 wins when all are valid.
